// File: rtl/post_idct_serializer_pkg.sv
// ---------------------------------------------------------------------------
// post_idct_serializer_pkg
// Shared decoder definitions for the post-IDCT serializer and its level_clamp
// stage. The pixel width and level offset defaults match the encoder's
// level-shift stage, so the forward and inverse paths use the same range.
//   DEF_PIXEL_WIDTH  : output pixel width (clamp ceiling 2^W-1)
//   DEF_LEVEL_OFFSET : offset added to each signed IDCT sample
//   pix_idx_t        : raster pixel index inside an 8x8 block, {y, x}
//   ser_state_t      : serializer FSM states
// ---------------------------------------------------------------------------
package post_idct_serializer_pkg;

  localparam int DEF_PIXEL_WIDTH  = 10;
  localparam int DEF_LEVEL_OFFSET = 512;

  typedef logic [5:0] pix_idx_t;

  localparam pix_idx_t LAST_PIX = 6'd63;

  typedef enum logic {
    SER_IDLE   = 1'b0,
    SER_STREAM = 1'b1
  } ser_state_t;

endpackage

// File: rtl/post_idct_serializer_level_clamp.sv
// ---------------------------------------------------------------------------
// level_clamp
// Purely combinational conversion of one signed IDCT sample into an unsigned
// pixel. The offset is added at 33 bits so that extreme 32-bit inputs cannot
// wrap before the saturation test.
//   sample : signed 32-bit IDCT result
//   pixel  : clamped pixel in 0 .. 2^PIXEL_WIDTH-1
// ---------------------------------------------------------------------------
module level_clamp
  import post_idct_serializer_pkg::*;
#(
  parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
  parameter int LEVEL_OFFSET = DEF_LEVEL_OFFSET
) (
  input  logic signed [31:0]      sample,
  output logic [PIXEL_WIDTH-1:0]  pixel
);

  localparam logic signed [32:0] OFFSET  = 33'(LEVEL_OFFSET);
  localparam logic signed [32:0] CEILING = 33'((64'd1 << PIXEL_WIDTH) - 64'd1);

  logic signed [32:0] shifted;

  assign shifted = $signed({sample[31], sample}) + OFFSET;

  // Saturate below zero and above the ceiling, pass the low bits otherwise.
  always_comb begin
    pixel = shifted[PIXEL_WIDTH-1:0];
    if (shifted < 33'sd0) begin
      pixel = '0;
    end else if (shifted > CEILING) begin
      pixel = '1;
    end
  end

endmodule

// File: rtl/post_idct_serializer.sv
// ---------------------------------------------------------------------------
// post_idct_serializer
// Takes a whole 8x8 block of signed IDCT results in one transfer, level-shifts
// and clamps every sample, and streams the block out in raster order. Two
// block slots let the IDCT deliver the next block while the current one is
// still being drained.
//   CLOCK, RESET          : rising-edge clock, asynchronous active-low reset
//   input_valid/ready     : block handshake; ready means the write slot is free
//   INPUT_DATA[8][8]      : signed IDCT block, [row][col]
//   output_valid/ready    : pixel handshake
//   OUTPUT_DATA           : clamped pixel
//   output_x / output_y   : column / row of the current pixel
//   output_last           : marks pixel (7,7)
// ---------------------------------------------------------------------------
module post_idct_serializer
  import post_idct_serializer_pkg::*;
#(
  parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
  parameter int LEVEL_OFFSET = DEF_LEVEL_OFFSET
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic signed [31:0]      INPUT_DATA [8][8],
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [PIXEL_WIDTH-1:0]  OUTPUT_DATA,
  output logic [2:0]              output_x,
  output logic [2:0]              output_y,
  output logic                    output_last
);

  logic [PIXEL_WIDTH-1:0] converted [64];
  logic [PIXEL_WIDTH-1:0] slot_mem [2][64];
  logic [1:0]             full;
  logic                   wr_sel;
  logic                   rd_sel;
  logic                   other_sel;
  logic                   accept;
  ser_state_t             state;
  pix_idx_t               pix;
  pix_idx_t               pix_next;

  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 8; c++) begin : g_col
      level_clamp #(
        .PIXEL_WIDTH  (PIXEL_WIDTH),
        .LEVEL_OFFSET (LEVEL_OFFSET)
      ) u_clamp (
        .sample (INPUT_DATA[r][c]),
        .pixel  (converted[r*8 + c])
      );
    end
  end

  assign input_ready = !full[wr_sel];
  assign accept      = input_valid && input_ready;
  assign other_sel   = ~rd_sel;
  assign pix_next    = pix + 6'd1;

  // Block storage is not reset: a slot's contents only matter while its full
  // flag is set, and reset clears the flags.
  always_ff @(posedge CLOCK) begin
    if (accept) begin
      for (int i = 0; i < 64; i++) begin
        slot_mem[wr_sel][i] <= converted[i];
      end
    end
  end

  // Slot bookkeeping and the serializer FSM share one block because a load and
  // a release can land on the same edge. They never target the same slot: a
  // load needs slot wr_sel empty, and a release needs slot rd_sel full.
  // Outputs are registered and pre-fetched from the slot memory so they change
  // only on a handshake and hold while the consumer stalls.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state        <= SER_IDLE;
      pix          <= '0;
      rd_sel       <= 1'b0;
      wr_sel       <= 1'b0;
      full         <= 2'b00;
      output_valid <= 1'b0;
      OUTPUT_DATA  <= '0;
      output_x     <= '0;
      output_y     <= '0;
      output_last  <= 1'b0;
    end else begin
      if (accept) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
      case (state)
        SER_IDLE: begin
          if (full[rd_sel]) begin
            state        <= SER_STREAM;
            pix          <= '0;
            output_valid <= 1'b1;
            OUTPUT_DATA  <= slot_mem[rd_sel][0];
            output_x     <= '0;
            output_y     <= '0;
            output_last  <= 1'b0;
          end
        end
        SER_STREAM: begin
          if (output_ready) begin
            if (pix == LAST_PIX) begin
              full[rd_sel] <= 1'b0;
              rd_sel       <= other_sel;
              pix          <= '0;
              output_x     <= '0;
              output_y     <= '0;
              output_last  <= 1'b0;
              // Chain straight into the other slot when it is already loaded.
              if (full[other_sel]) begin
                OUTPUT_DATA <= slot_mem[other_sel][0];
              end else begin
                state        <= SER_IDLE;
                output_valid <= 1'b0;
              end
            end else begin
              pix         <= pix_next;
              OUTPUT_DATA <= slot_mem[rd_sel][pix_next];
              output_x    <= pix_next[2:0];
              output_y    <= pix_next[5:3];
              output_last <= (pix_next == LAST_PIX);
            end
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

endmodule
